// File: rtl/led_btn_pkg.sv
// Shared constants and helpers for the push-button LED controller.
package led_btn_pkg;

  // Default timing at the 1 MHz board clock.
  localparam int unsigned DefDbCycles   = 10000;
  localparam int unsigned DefHoldCycles = 1000000;
  localparam int unsigned DefBlinkHalf  = 250000;

  typedef enum logic {
    MODE_STEADY = 1'b0,
    MODE_BLINK  = 1'b1
  } mode_e;

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, optional inversion, debounce counter
// and a registered press strobe.
module btn_debounce
  import led_btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = DefDbCycles,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic btn_db,
  output logic press_pulse
);

  localparam int unsigned     CntW    = cnt_width(DB_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);
  localparam logic            BtnIdle = BTN_ACTIVE_LOW;

  logic [1:0]      sync_q;
  logic            pressed;
  logic [CntW-1:0] cnt_q;
  logic            db_q;
  logic            db_prev_q;
  logic            pulse_q;

  assign pressed = sync_q[1] ^ BtnIdle;

  // Sync flops reset to the released pin level so a button held through reset
  // still needs the full sync + debounce time to register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= {2{BtnIdle}};
      cnt_q     <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn};
      db_prev_q <= db_q;
      pulse_q   <= db_q & ~db_prev_q;
      if (pressed == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        db_q  <= pressed;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign btn_db      = db_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/led_btn_ctrl.sv
// N-channel push-button LED toggler. Define LED_BLINK_EN to add long-press
// steady/blink mode switching with a shared blink prescaler.
module led_btn_ctrl
  import led_btn_pkg::*;
#(
  parameter int unsigned       NUM_CH         = 4,
  parameter int unsigned       DB_CYCLES      = DefDbCycles,
  parameter int unsigned       HOLD_CYCLES    = DefHoldCycles,
  parameter int unsigned       BLINK_HALF     = DefBlinkHalf,
  parameter bit                BTN_ACTIVE_LOW = 1'b1,
  parameter logic [NUM_CH-1:0] LED_RST_VAL    = {NUM_CH{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] btn_db,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] blink_mode
);

  if (DB_CYCLES < 1 || HOLD_CYCLES < 1 || BLINK_HALF < 1) begin : g_bad_timing
    $error("led_btn_ctrl: timing parameters must be >= 1");
  end

  logic [NUM_CH-1:0] db;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] led_flip;
  logic [NUM_CH-1:0] led_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    btn_debounce #(
      .DB_CYCLES      (DB_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_debounce (
      .clk         (clk),
      .reset       (reset),
      .btn         (btn[i]),
      .btn_db      (db[i]),
      .press_pulse (pulse[i])
    );
  end

`ifdef LED_BLINK_EN
  localparam int unsigned      HoldW   = cnt_width(HOLD_CYCLES);
  localparam int unsigned      PreW    = cnt_width(BLINK_HALF);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES);
  localparam logic [PreW-1:0]  PreLast = PreW'(BLINK_HALF - 1);

  logic [PreW-1:0]   pre_q;
  logic              blink_tick;
  logic [HoldW-1:0]  hold_q [NUM_CH];
  logic [NUM_CH-1:0] fired_q;
  mode_e             mode_q [NUM_CH];
  logic [NUM_CH-1:0] blink_mask;

  assign blink_tick = (pre_q == PreLast);

  always_ff @(posedge clk) begin
    if (reset || blink_tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PreW'(1);
    end
  end

  // Hold count saturates; fired blocks re-trigger until the button is released.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        hold_q[i]  <= '0;
        fired_q[i] <= 1'b0;
        mode_q[i]  <= MODE_STEADY;
      end else if (!db[i]) begin
        hold_q[i]  <= '0;
        fired_q[i] <= 1'b0;
      end else if (hold_q[i] != HoldMax) begin
        hold_q[i] <= hold_q[i] + HoldW'(1);
      end else if (!fired_q[i]) begin
        fired_q[i] <= 1'b1;
        mode_q[i]  <= (mode_q[i] == MODE_BLINK) ? MODE_STEADY : MODE_BLINK;
      end
    end
  end

  always_comb begin
    blink_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      blink_mask[i] = (mode_q[i] == MODE_BLINK);
    end
  end

  // OR, not XOR: a press coinciding with a blink tick inverts only once.
  assign led_flip   = pulse | (blink_tick ? blink_mask : '0);
  assign blink_mode = blink_mask;
`else
  assign led_flip   = pulse;
  assign blink_mode = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= LED_RST_VAL;
    end else begin
      led_q <= led_q ^ led_flip;
    end
  end

  assign led         = led_q;
  assign btn_db      = db;
  assign press_pulse = pulse;

endmodule

// File: tb/tb_led_btn_ctrl.sv
// Directed scoreboard bench for led_btn_ctrl; blink expectations follow
// whether LED_BLINK_EN is defined.
module tb_led_btn_ctrl;

  localparam int unsigned NumCh      = 4;
  localparam int unsigned DbCycles   = 4;
  localparam int unsigned HoldCycles = 20;
  localparam int unsigned BlinkHalf  = 8;
`ifdef LED_BLINK_EN
  localparam bit BlinkEn = 1'b1;
`else
  localparam bit BlinkEn = 1'b0;
`endif

  // Cycle offsets from the press edge: sync(2) + debounce, then strobe, then
  // the hold count starting the cycle after btn_db rises.
  localparam int DbRise  = 2 + DbCycles;
  localparam int PulseAt = DbRise + 1;
  localparam int FireAt  = DbRise + HoldCycles + 1;

  logic             clk;
  logic             reset;
  logic [NumCh-1:0] btn;
  logic [NumCh-1:0] led;
  logic [NumCh-1:0] btn_db;
  logic [NumCh-1:0] press_pulse;
  logic [NumCh-1:0] blink_mode;

  led_btn_ctrl #(
    .NUM_CH         (NumCh),
    .DB_CYCLES      (DbCycles),
    .HOLD_CYCLES    (HoldCycles),
    .BLINK_HALF     (BlinkHalf),
    .BTN_ACTIVE_LOW (1'b1),
    .LED_RST_VAL    (4'b1111)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .led         (led),
    .btn_db      (btn_db),
    .press_pulse (press_pulse),
    .blink_mode  (blink_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Non-reset edges since the last reset edge; the blink tick lands on multiples of BlinkHalf.
  int rc = 0;
  always @(posedge clk) rc <= reset ? 0 : rc + 1;

  typedef struct {
    string      tag;
    int         at;
    logic [3:0] led;
    logic [3:0] db;
    logic [3:0] pulse;
    logic [3:0] bm;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] exp_led   = 4'b1111;
  logic [3:0] exp_db    = 4'b0000;
  logic [3:0] exp_pulse = 4'b0000;
  logic [3:0] exp_bm    = 4'b0000;

  task automatic check_due();
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      e = sb_q.pop_front();
      checks++;
      assert (led === e.led) else begin
        errors++;
        $error("FAIL %s led @%0d: got %b want %b", e.tag, cyc, led, e.led);
      end
      checks++;
      assert (btn_db === e.db) else begin
        errors++;
        $error("FAIL %s btn_db @%0d: got %b want %b", e.tag, cyc, btn_db, e.db);
      end
      checks++;
      assert (press_pulse === e.pulse) else begin
        errors++;
        $error("FAIL %s press_pulse @%0d: got %b want %b", e.tag, cyc, press_pulse, e.pulse);
      end
      checks++;
      assert (blink_mode === e.bm) else begin
        errors++;
        $error("FAIL %s blink_mode @%0d: got %b want %b", e.tag, cyc, blink_mode, e.bm);
      end
    end
  endtask

  // Predict the outputs after the next clock edge, queue them, advance to the
  // following falling edge and compare.
  task automatic adv(input logic [3:0] new_pulse, input logic [3:0] bm_flip,
                     input logic [3:0] db_set, input logic [3:0] db_clr, input string tag);
    logic tick;
    exp_t e;
    tick = !reset && ((rc + 1) % BlinkHalf == 0);
    if (reset) begin
      exp_led   = 4'b1111;
      exp_db    = 4'b0000;
      exp_pulse = 4'b0000;
      exp_bm    = 4'b0000;
    end else begin
      exp_led   = exp_led ^ exp_pulse ^ (tick ? (exp_bm & ~exp_pulse) : 4'b0000);
      exp_bm    = exp_bm ^ (BlinkEn ? bm_flip : 4'b0000);
      exp_db    = (exp_db | db_set) & ~db_clr;
      exp_pulse = new_pulse;
    end
    e.tag   = tag;
    e.at    = cyc + 1;
    e.led   = exp_led;
    e.db    = exp_db;
    e.pulse = exp_pulse;
    e.bm    = exp_bm;
    sb_q.push_back(e);
    @(negedge clk);
    cyc++;
    check_due();
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) adv(4'b0, 4'b0, 4'b0, 4'b0, tag);
  endtask

  // Press the masked buttons for len cycles and follow them for total cycles.
  task automatic press(input logic [3:0] mask, input int len, input int total,
                       input string tag);
    btn = btn & ~mask;
    for (int k = 1; k <= total; k++) begin
      adv((k == PulseAt) ? mask : 4'b0,
          (k == FireAt && len > int'(HoldCycles)) ? mask : 4'b0,
          (k == DbRise) ? mask : 4'b0,
          (k == len + DbRise) ? mask : 4'b0,
          tag);
      if (k == len) btn = btn | mask;
    end
  endtask

  task automatic align();
    for (int i = 0; i < int'(BlinkHalf) && (rc % BlinkHalf) != 0; i++) begin
      adv(4'b0, 4'b0, 4'b0, 4'b0, "align");
    end
  endtask

  initial begin
    reset = 1'b1;
    btn   = 4'b1111;
    idle(3, "reset");
    reset = 1'b0;
    idle(2, "post_reset");

    press(4'b1111, 10, 18, "simul_on");
    press(4'b1111, 10, 18, "simul_off");
    press(4'b0001, 12, 20, "clean");

    for (int r = 0; r < 5; r++) begin
      btn[1] = 1'b0;
      idle(3, "bounce_lo");
      btn[1] = 1'b1;
      idle(3, "bounce_hi");
    end
    idle(4, "bounce_settle");

    // Debounce count one short of completion when reset hits.
    btn[2] = 1'b0;
    idle(5, "mid_pre");
    reset = 1'b1;
    idle(2, "mid_rst");
    reset = 1'b0;
    press(4'b0100, 10, 18, "mid_post");

    align();
    press(4'b1000, 40, 50, "long1");
    align();
    press(4'b1000, 8, 16, "coincide");
    align();
    press(4'b1000, 40, 50, "long2");
    idle(20, "frozen");

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
